// File: rtl/spi_i2s_ipi_i2s_tx.sv
// I2S stereo transmitter: single-entry frame buffer feeding a 2W-bit shift register, paced by clk_div ticks.
// Optional underrun pulse output is built only when SPI_I2S_IPI_I2ST_UNDERRUN_EN is defined.
module spi_i2s_ipi_i2s_tx #(
  parameter int PARAM_DATA_WIDTH = 16
) (
  input  logic                            i2st_clk,
  input  logic                            i2st_rst_n,
  input  logic                            i2st_time_base_i,
  input  logic                            i2st_enable_i,
  input  logic [2*PARAM_DATA_WIDTH-1:0]   i2st_data_i,
  input  logic                            i2st_valid_i,
  output logic                            i2st_ready_o,
  output logic                            i2st_sck_o,
  output logic                            i2st_ws_o,
  output logic                            i2st_sd_o,
  output logic                            i2st_busy_o,
  output logic                            i2st_underrun_o
);

  localparam int W  = PARAM_DATA_WIDTH;
  localparam int FW = 2 * W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [5:0] LAST_BIT = 6'(FW - 1);
  localparam logic [5:0] WS_LO    = 6'(W - 1);
  localparam logic [5:0] WS_HI    = 6'(FW - 2);

  logic [0:0]    state_q, state_d;
  logic [FW-1:0] buf_q, buf_d;
  logic          buf_full_q, buf_full_d;
  logic [FW-1:0] shreg_q, shreg_d;
  logic [5:0]    bitcnt_q, bitcnt_d;
  logic          sck_q, sck_d;
  logic          ws_q, ws_d;
  logic          accept;
  logic          consume;
  logic [5:0]    next_cnt;
`ifdef SPI_I2S_IPI_I2ST_UNDERRUN_EN
  logic          underrun_q, underrun_d;
`endif

  // Accept and consume are mutually exclusive: accepting needs an empty buffer, consuming a full one.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    sck_d      = sck_q;
    ws_d       = ws_q;
    consume    = 1'b0;
    accept     = i2st_valid_i && !buf_full_q;
    next_cnt   = bitcnt_q + 6'd1;
`ifdef SPI_I2S_IPI_I2ST_UNDERRUN_EN
    underrun_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i2st_time_base_i && i2st_enable_i && buf_full_q) begin
          state_d  = ST_RUN;
          shreg_d  = buf_q;
          consume  = 1'b1;
          bitcnt_d = 6'd0;
          ws_d     = 1'b0;
          sck_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (i2st_time_base_i) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bitcnt_q == LAST_BIT) begin
              // Frame boundary: stop, reload from the buffer, or send silence.
              bitcnt_d = 6'd0;
              ws_d     = 1'b0;
              if (!i2st_enable_i) begin
                state_d = ST_IDLE;
                shreg_d = '0;
              end else if (buf_full_q) begin
                shreg_d = buf_q;
                consume = 1'b1;
              end else begin
                shreg_d = '0;
`ifdef SPI_I2S_IPI_I2ST_UNDERRUN_EN
                underrun_d = 1'b1;
`endif
              end
            end else begin
              bitcnt_d = next_cnt;
              shreg_d  = {shreg_q[FW-2:0], 1'b0};
              ws_d     = (next_cnt >= WS_LO) && (next_cnt <= WS_HI);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (accept) begin
      buf_d      = i2st_data_i;
      buf_full_d = 1'b1;
    end else if (consume) begin
      buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge i2st_clk or negedge i2st_rst_n) begin
    if (!i2st_rst_n) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shreg_q    <= '0;
      bitcnt_q   <= 6'd0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      sck_q      <= sck_d;
      ws_q       <= ws_d;
    end
  end

`ifdef SPI_I2S_IPI_I2ST_UNDERRUN_EN
  always_ff @(posedge i2st_clk or negedge i2st_rst_n) begin
    if (!i2st_rst_n) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end
  assign i2st_underrun_o = underrun_q;
`else
  assign i2st_underrun_o = 1'b0;
`endif

  // The shift register MSB is the current serial bit; it is zero whenever idle.
  assign i2st_sd_o    = shreg_q[FW-1];
  assign i2st_sck_o   = sck_q;
  assign i2st_ws_o    = ws_q;
  assign i2st_ready_o = !buf_full_q;
  assign i2st_busy_o  = (state_q == ST_RUN);

endmodule

// File: tb/tb_spi_i2s_ipi_i2s_tx.sv
// Directed bench for spi_i2s_ipi_i2s_tx (W=16): expected {ws,sd} bits are queued by stimulus and
// popped by a monitor on every SCK rising edge.
module tb_spi_i2s_ipi_i2s_tx;

  localparam int W  = 16;
  localparam int FW = 2 * W;

  logic          clk;
  logic          rst_n;
  logic          time_base;
  logic          enable;
  logic [FW-1:0] data;
  logic          valid;
  logic          ready;
  logic          sck;
  logic          ws;
  logic          sd;
  logic          busy;
  logic          underrun;

  logic [1:0] exp_q[$];
  int total     = 0;
  int bad       = 0;
  int mon_bits  = 0;
  int under_cnt = 0;
  int tick_div  = 1;
  int tick_cnt  = 0;
  int exp_under;
  int base;

  spi_i2s_ipi_i2s_tx #(.PARAM_DATA_WIDTH(W)) dut (
    .i2st_clk        (clk),
    .i2st_rst_n      (rst_n),
    .i2st_time_base_i(time_base),
    .i2st_enable_i   (enable),
    .i2st_data_i     (data),
    .i2st_valid_i    (valid),
    .i2st_ready_o    (ready),
    .i2st_sck_o      (sck),
    .i2st_ws_o       (ws),
    .i2st_sd_o       (sd),
    .i2st_busy_o     (busy),
    .i2st_underrun_o (underrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // time base: one tick every tick_div cycles
  initial begin
    time_base = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_div <= 1) begin
        time_base = 1'b1;
        tick_cnt  = 0;
      end else begin
        time_base = (tick_cnt == tick_div - 1);
        tick_cnt  = (tick_cnt + 1) % tick_div;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic       sck_prev;
    logic [1:0] e;
    sck_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (underrun) under_cnt++;
      if (sck && !sck_prev) begin
        mon_bits++;
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 32'(mon_bits), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ws_sd_bit", {30'd0, ws, sd}, {30'd0, e});
        end
      end
      sck_prev = sck;
    end
  end

  // driver tasks
  task automatic push_frame(input logic [FW-1:0] f, input int n);
    logic wsb;
    for (int k = 0; k < n; k++) begin
      wsb = (k >= W - 1) && (k <= FW - 2);
      exp_q.push_back({wsb, f[FW-1-k]});
    end
  endtask

  task automatic wait_ready(input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ready) begin
        ok = 1;
        break;
      end
      @(negedge clk); #1;
    end
    if (ok == 0) check(name, 32'(ready), 32'd1);
  endtask

  task automatic write_frame(input logic [FW-1:0] f, input string name);
    wait_ready({name, "_wait_ready"});
    data  = f;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    check({name, "_ready_drop"}, 32'(ready), 32'd0);
  endtask

  task automatic wait_bits(input int n, input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      if (mon_bits >= n) begin
        ok = 1;
        break;
      end
      @(negedge clk); #1;
    end
    if (ok == 0) check(name, 32'(mon_bits), 32'(n));
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (busy == lvl) begin
        ok = 1;
        break;
      end
      @(negedge clk); #1;
    end
    if (ok == 0) check(name, 32'(busy), 32'(lvl));
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_sck"}, 32'(sck), 32'd0);
    check({name, "_ws"}, 32'(ws), 32'd0);
    check({name, "_sd"}, 32'(sd), 32'd0);
    check({name, "_ready"}, 32'(ready), 32'd1);
    check({name, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  initial begin
`ifdef SPI_I2S_IPI_I2ST_UNDERRUN_EN
    exp_under = 1;
`else
    exp_under = 0;
`endif
    rst_n  = 1'b0;
    enable = 1'b0;
    valid  = 1'b0;
    data   = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk); #1;

    // A: single frame, tick every cycle, enable dropped mid-frame
    base = mon_bits;
    push_frame(32'hA5A5_3C3C, 32);
    write_frame(32'hA5A5_3C3C, "a_wr");
    enable = 1'b1;
    wait_busy(1'b1, "a_start");
    check("a_busy", 32'(busy), 32'd1);
    wait_bits(base + 5, "a_bits5");
    enable = 1'b0;
    wait_busy(1'b0, "a_stop");
    check_idle("a_end");
    check("a_bits", 32'(mon_bits), 32'(base + 32));
    check("a_q_empty", 32'(exp_q.size()), 32'd0);

    // B: back-to-back frames, buffer refilled ahead of the boundary
    base = mon_bits;
    push_frame(32'h8000_0001, 32);
    push_frame(32'h7FFF_FFFE, 32);
    write_frame(32'h8000_0001, "b_wr1");
    enable = 1'b1;
    write_frame(32'h7FFF_FFFE, "b_wr2");
    wait_ready("b_ready_rise");
    check("b_ready_at_boundary", 32'(mon_bits), 32'(base + 32));
    check("b_busy_cont", 32'(busy), 32'd1);
    enable = 1'b0;
    wait_busy(1'b0, "b_stop");
    check_idle("b_end");
    check("b_bits", 32'(mon_bits), 32'(base + 64));
    check("b_q_empty", 32'(exp_q.size()), 32'd0);

    // C: underrun, with a write landing on the boundary cycle itself
    base = mon_bits;
    push_frame(32'hC3C3_0F0F, 32);
    push_frame(32'h0000_0000, 32);
    push_frame(32'h5AA5_9669, 32);
    write_frame(32'hC3C3_0F0F, "c_wr1");
    enable = 1'b1;
    wait_bits(base + 32, "c_bits32");
    write_frame(32'h5AA5_9669, "c_wr2");
    wait_bits(base + 72, "c_bits72");
    enable = 1'b0;
    wait_busy(1'b0, "c_stop");
    check_idle("c_end");
    check("c_bits", 32'(mon_bits), 32'(base + 96));
    check("c_q_empty", 32'(exp_q.size()), 32'd0);

    // D: tick every 4th cycle, enable dropped at bitcnt 10
    tick_div = 4;
    base = mon_bits;
    push_frame(32'h1234_ABCD, 32);
    write_frame(32'h1234_ABCD, "d_wr");
    enable = 1'b1;
    wait_bits(base + 11, "d_bits11");
    enable = 1'b0;
    check("d_busy_mid", 32'(busy), 32'd1);
    wait_busy(1'b0, "d_stop");
    check_idle("d_end");
    check("d_bits", 32'(mon_bits), 32'(base + 32));
    check("d_q_empty", 32'(exp_q.size()), 32'd0);
    tick_div = 1;

    // E: reset at bitcnt 20 with the buffer full
    base = mon_bits;
    push_frame(32'hF0E1_D2C3, 21);
    write_frame(32'hF0E1_D2C3, "e_wr1");
    enable = 1'b1;
    write_frame(32'h1357_9BDF, "e_wr2");
    wait_bits(base + 21, "e_bits21");
    rst_n = 1'b0;
    #1;
    check_idle("e_reset");
    check("e_q_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    check("e_no_tx_busy", 32'(busy), 32'd0);
    check("e_no_tx_bits", 32'(mon_bits), 32'(base + 21));
    check("e_ready", 32'(ready), 32'd1);
    push_frame(32'h0FF0_A55A, 32);
    write_frame(32'h0FF0_A55A, "e_wr3");
    wait_busy(1'b1, "e_restart");
    wait_bits(base + 25, "e_bits25");
    enable = 1'b0;
    wait_busy(1'b0, "e_stop");
    check_idle("e_end");
    check("e_bits", 32'(mon_bits), 32'(base + 53));
    check("e_q_empty2", 32'(exp_q.size()), 32'd0);

    repeat (4) @(negedge clk);
    check("underrun_cnt", 32'(under_cnt), 32'(exp_under));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_i2s_ipi_i2s_tx.md
SPI_I2S_IPI_I2S_TX -- requirements
Module: spi_i2s_ipi_i2s_tx

Interface
REQ-001 PARAM_DATA_WIDTH, default 16: bits per channel (W), legal range 8..32.
REQ-002 i2st_clk  input  1  system clock; all logic on rising edge.
REQ-003 i2st_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i2st_time_base_i  input  1  one-cycle tick from spi_i2s_ipi_clk_div; each tick = one SCK half-period.
REQ-005 i2st_enable_i  input  1  transmitter enable.
REQ-006 i2st_data_i  input  2W  stereo frame {left[2W-1:W], right[W-1:0]}.
REQ-007 i2st_valid_i  input  1  frame valid.
REQ-008 i2st_ready_o  output  1  holding buffer empty; frame accepted when valid_i && ready_o at a rising edge.
REQ-009 i2st_sck_o  output  1  I2S serial clock.
REQ-010 i2st_ws_o  output  1  word select; 0 = left, 1 = right.
REQ-011 i2st_sd_o  output  1  serial data, MSB first.
REQ-012 i2st_busy_o  output  1  high while in RUN.
REQ-013 i2st_underrun_o  output  1  one-cycle pulse on underrun (see Configuration).

Function
REQ-014 Single-entry holding buffer (2W bits) plus 2W-bit shift register, 6-bit bit counter bitcnt (0..2W-1).
REQ-015 ready_o = !buf_full; ready_o drops the cycle after acceptance; writes with ready_o low are ignored.
REQ-016 FSM states IDLE, RUN; no activity on i2st_sck_o/ws_o/sd_o in IDLE (all 0).
REQ-017 IDLE -> RUN on a tick with enable_i=1 and buf_full=1: shift register loaded from buffer, buffer emptied, bitcnt=0, sd_o=left MSB, ws_o=0, sck_o stays 0.
REQ-018 In RUN, tick with sck_o=0: sck_o -> 1 (rising edge, receiver sample point); no other change.
REQ-019 In RUN, tick with sck_o=1: sck_o -> 0, bitcnt increments (wraps 2W-1 -> 0), sd_o = frame bit for new bitcnt (bit 2W-1-bitcnt of frame).
REQ-020 ws_o = 1 when bitcnt in W-1..2W-2, else 0 (WS leads data by one SCK, standard I2S).
REQ-021 Frame boundary = falling-edge tick with bitcnt 2W-1 -> 0: if enable_i=0, go IDLE (sck_o, ws_o, sd_o = 0); else if buf_full, load next frame and empty buffer; else load all-zero frame and flag underrun.
REQ-022 enable_i deassert mid-frame: current frame completes; transition at REQ-021 only.
REQ-023 Boundary with buffer empty and valid_i && ready_o same cycle: underrun still occurs; incoming frame stored in buffer for next boundary (no bypass).
REQ-024 Ticks without enable_i in IDLE are ignored; ticks arriving while sck_o toggles are never dropped or merged.
REQ-025 busy_o = 1 in RUN, 0 in IDLE; outputs are registered, no combinational input-to-output paths except none.

Reset
REQ-026 On i2st_rst_n=0, immediately: state IDLE, buf_full=0, shift register 0, bitcnt 0, sck_o=0, ws_o=0, sd_o=0, busy_o=0, underrun_o=0, ready_o=1.
REQ-027 Reset mid-frame aborts the frame; buffered frame discarded; no underrun pulse generated.

Configuration
REQ-028 Macro SPI_I2S_IPI_I2ST_UNDERRUN_EN defined: i2st_underrun_o pulses one cycle at each REQ-021 underrun boundary.
REQ-029 Macro undefined: i2st_underrun_o tied 0, underrun detection logic omitted; zero frame still transmitted.

Verification (W=16)
REQ-030 Tick every cycle, write 0xA5A5_3C3C, enable -> SCK period 2 cycles; SD sequence 1010_0101_1010_0101 then 0011_1100_0011_1100 sampled on SCK rising; WS low bits 0..14, high 15..30.
REQ-031 Back-to-back writes 0x8000_0001, 0x7FFF_FFFE kept ahead -> continuous frames, no underrun, ready_o re-rises one cycle after each boundary.
REQ-032 No second frame supplied -> second frame SD all 0, underrun_o one pulse at boundary (macro on), 0 (macro off).
REQ-033 Tick every 4th cycle (clk_div sel=2), enable dropped at bitcnt 10 -> frame completes, IDLE at boundary, busy_o 0, all serial outputs 0.
REQ-034 Reset asserted at bitcnt 20 with buffer full -> all outputs to REQ-026 values same cycle; after release ready_o=1, no transmission until new write.
